// File: rtl/id_ex_hazard_ctl.sv
// Hazard/stall controller at the ID/EX consumer end: load-use stalls, multi-cycle
// MDU stalls, MEM-resolved branch flushes and a saturating stall-cycle counter.
module id_ex_hazard_ctl #(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [2:0]       ex_mem_ctl,
    input  logic [4:0]       ex_rt,
    input  logic             ex_mdu_start,
    input  logic             mem_branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {IDLE, MDU_BUSY} state_t;

    // The start cycle already stalls, so MDU_BUSY spans MDU_LATENCY-2 cycles and the
    // whole op stalls MDU_LATENCY-1; the counter value is the remaining busy cycles minus one.
    localparam logic [3:0] MDU_LOAD = 4'((MDU_LATENCY > 2) ? MDU_LATENCY - 3 : 0);

    state_t     state, state_nxt;
    logic [3:0] mdu_cnt, mdu_cnt_nxt;
    logic       lu;

    assign lu = ex_mem_ctl[1] && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path infers a latch.
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        mdu_busy     = 1'b0;
        mdu_done     = 1'b0;
        state_nxt    = state;
        mdu_cnt_nxt  = mdu_cnt;

        if (mem_branch_taken) begin
            // The EX instruction is squashed, so an MDU start or an op in flight is dropped.
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
            state_nxt    = IDLE;
            mdu_cnt_nxt  = 4'd0;
        end else if (state == MDU_BUSY) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            mdu_busy     = 1'b1;
            if (mdu_cnt == 4'd0) begin
                mdu_done  = 1'b1;
                state_nxt = IDLE;
            end else begin
                mdu_cnt_nxt = mdu_cnt - 4'd1;
            end
        end else if (ex_mdu_start) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            state_nxt    = MDU_BUSY;
            mdu_cnt_nxt  = MDU_LOAD;
        end else if (lu) begin
            // One bubble into ID/EX; next cycle the load sits in MEM and the hazard clears.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mdu_cnt      <= 4'd0;
            stall_cycles <= '0;
        end else begin
            // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
            state   <= state_nxt;
            mdu_cnt <= mdu_cnt_nxt;
            if (!pc_write && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule
